// File: rtl/cdc_pkt_arbiter.sv
// cdc_pkt_arbiter: packet-locked round-robin arbiter feeding the AXI-side CDC FIFO.
// Define RAVENOC_ARB_STATS_EN to add per-requester saturating packet counters.
module cdc_pkt_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FLIT_WIDTH = 34,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk_axi,
    input  logic                        arst_axi,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*FLIT_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_tail_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic                        flit_valid_o,
    output logic [FLIT_WIDTH-1:0]       flit_data_o,
    output logic                        flit_tail_o,
    input  logic                        flit_ready_i,
    output logic [$clog2(N_REQ)-1:0]    grant_id_o,
    output logic                        busy_o
`ifdef RAVENOC_ARB_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic [N_REQ*CNT_WIDTH-1:0]  pkt_cnt_o
`endif
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         rr_d;
    logic [IW-1:0]         owner;
    logic [IW-1:0]         owner_d;
    logic [IW-1:0]         win;
    logic [IW-1:0]         sel;
    logic                  found;
    logic                  slot_free;
    logic                  hs;
    logic [FLIT_WIDTH-1:0] data_a [N_REQ];

    // Modular add that also wraps correctly for non-power-of-2 N_REQ.
    function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] base,
                                             input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_a[i] = req_data_i[i*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    assign slot_free = !flit_valid_o || flit_ready_i;
    assign busy_o    = (state == LOCKED) || flit_valid_o;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid_i[rr_add(rr_ptr, k)]) begin
                found = 1'b1;
                win   = rr_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_d     = state;
        rr_d        = rr_ptr;
        owner_d     = owner;
        req_ready_o = '0;
        sel         = win;
        hs          = 1'b0;
        unique case (state)
            IDLE: begin
                if (slot_free && found) begin
                    req_ready_o[win] = 1'b1;
                    hs               = 1'b1;
                    if (req_tail_i[win]) begin
                        rr_d = rr_add(win, 1);
                    end else begin
                        state_d = LOCKED;
                        owner_d = win;
                    end
                end
            end
            LOCKED: begin
                sel                = owner;
                req_ready_o[owner] = slot_free;
                hs = slot_free && req_valid_i[owner];
                if (hs && req_tail_i[owner]) begin
                    state_d = IDLE;
                    rr_d    = rr_add(owner, 1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Nobody is readied while the block is held in reset.
        if (!arst_axi) begin
            req_ready_o = '0;
            hs          = 1'b0;
        end
    end

    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_d;
            owner  <= owner_d;
        end
    end

    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            flit_valid_o <= 1'b0;
            flit_data_o  <= '0;
            flit_tail_o  <= 1'b0;
            grant_id_o   <= '0;
        end else if (hs) begin
            flit_valid_o <= 1'b1;
            flit_data_o  <= data_a[sel];
            flit_tail_o  <= req_tail_i[sel];
            grant_id_o   <= sel;
        end else if (flit_ready_i) begin
            flit_valid_o <= 1'b0;
        end
    end

`ifdef RAVENOC_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [N_REQ];

    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (stats_clr_i) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (hs && req_tail_i[sel] && (cnt_q[sel] != '1)) begin
            cnt_q[sel] <= cnt_q[sel] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pkt_cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cdc_pkt_arbiter.sv
// tb_cdc_pkt_arbiter: randomized + directed scoreboard bench for cdc_pkt_arbiter.
// A per-cycle arbitration model predicts readies and the output flit stream.
module tb_cdc_pkt_arbiter;

    localparam int N  = 4;
    localparam int FW = 34;
    localparam int CW = 16;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              arst_axi = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*FW-1:0]   req_data_i = '0;
    logic [N-1:0]      req_tail_i = '0;
    logic [N-1:0]      req_ready_o;
    logic              flit_valid_o;
    logic [FW-1:0]     flit_data_o;
    logic              flit_tail_o;
    logic              flit_ready_i = 1'b0;
    logic [IW-1:0]     grant_id_o;
    logic              busy_o;
`ifdef RAVENOC_ARB_STATS_EN
    logic              stats_clr_i = 1'b0;
    logic [N*CW-1:0]   pkt_cnt_o;
    int                m_cnt [N];
`endif

    cdc_pkt_arbiter #(
        .N_REQ     (N),
        .FLIT_WIDTH(FW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_axi     (clk),
        .arst_axi    (arst_axi),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_tail_i  (req_tail_i),
        .req_ready_o (req_ready_o),
        .flit_valid_o(flit_valid_o),
        .flit_data_o (flit_data_o),
        .flit_tail_o (flit_tail_o),
        .flit_ready_i(flit_ready_i),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
`ifdef RAVENOC_ARB_STATS_EN
        ,
        .stats_clr_i (stats_clr_i),
        .pkt_cnt_o   (pkt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0] d;
        logic          t;
        logic [IW-1:0] g;
    } exp_t;

    exp_t          sb_q[$];
    logic [FW:0]   src_q [N][$];
    int            gnt_log[$];
    int            exp_g[$];
    int            pkt_seq [N];
    int            checks = 0;
    int            failures = 0;
    int            bubble_pct = 0;
    int            rdy_pct = 100;
    logic [N-1:0]  pause = '0;
    logic [N-1:0]  acc = '0;
    logic [N-1:0]  exp_rdy;
    bit            m_full = 0;
    bit            m_locked = 0;
    int            m_rr = 0;
    int            m_owner = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    task automatic add_pkt(input int i, input int len);
        logic [FW-1:0] d;
        for (int f = 0; f < len; f++) begin
            d = {2'(i), 16'(pkt_seq[i]), 16'(f)};
            src_q[i].push_back({(f == len - 1), d});
        end
        pkt_seq[i]++;
    endtask

    function automatic int src_total();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input int lim);
        bit done = 0;
        for (int c = 0; c < lim && !done; c++) begin
            @(negedge clk);
            done = (src_total() == 0) && (sb_q.size() == 0) &&
                   !flit_valid_o && !busy_o;
        end
        check("drain", done, 1);
    endtask

    task automatic check_gnt(input string nm);
        check({nm, "_len"}, gnt_log.size(), exp_g.size());
        for (int k = 0; k < exp_g.size() && k < gnt_log.size(); k++)
            check(nm, gnt_log[k], exp_g[k]);
        gnt_log.delete();
    endtask

    // Stimulus driver: holds each flit until accepted, random bubbles between.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            flit_ready_i = ($urandom_range(0, 99) < rdy_pct);
            for (int i = 0; i < N; i++) begin
                if (!arst_axi) begin
                    req_valid_i[i] = 1'b0;
                    continue;
                end
                if (acc[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
                if (req_valid_i[i] && !acc[i]) continue;
                if (src_q[i].size() > 0 && !pause[i] &&
                    $urandom_range(0, 99) >= bubble_pct) begin
                    req_valid_i[i]            = 1'b1;
                    req_data_i[i*FW +: FW]    = src_q[i][0][FW-1:0];
                    req_tail_i[i]             = src_q[i][0][FW];
                end else begin
                    req_valid_i[i] = 1'b0;
                end
            end
        end
    end

    // Reference model: predicts readies, occupancy and pushes expected flits.
    initial begin
        exp_t e;
        int   w;
        forever begin
            @(negedge clk);
            if (!arst_axi) begin
                m_full = 0; m_locked = 0; m_rr = 0; m_owner = 0;
                acc = '0;
                sb_q.delete();
`ifdef RAVENOC_ARB_STATS_EN
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
                continue;
            end
            exp_rdy = '0;
            if (!m_full || flit_ready_i) begin
                if (m_locked) begin
                    exp_rdy[m_owner] = 1'b1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (req_valid_i[(m_rr + k) % N]) begin
                            exp_rdy[(m_rr + k) % N] = 1'b1;
                            break;
                        end
                    end
                end
            end
            check("req_ready", req_ready_o, exp_rdy);
            check("flit_valid", flit_valid_o, m_full);
            check("busy", busy_o, m_locked || m_full);
            acc = req_valid_i & exp_rdy;
            w = -1;
            for (int i = 0; i < N; i++) if (acc[i]) w = i;
            if (w >= 0) begin
                e.d = req_data_i[w*FW +: FW];
                e.t = req_tail_i[w];
                e.g = IW'(w);
                sb_q.push_back(e);
                if (e.t) begin
                    m_locked = 0;
                    m_rr     = (w + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = w;
                end
                m_full = 1;
            end else if (flit_ready_i) begin
                m_full = 0;
            end
`ifdef RAVENOC_ARB_STATS_EN
            if (stats_clr_i) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end else if (w >= 0 && e.t && m_cnt[w] < (1 << CW) - 1) begin
                m_cnt[w]++;
            end
`endif
        end
    end

    // Monitor: compares the presented flit with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!arst_axi || !flit_valid_o) continue;
            if (sb_q.size() == 0) begin
                check("sb_underflow", flit_valid_o, 0);
                continue;
            end
            check("flit_data", flit_data_o, sb_q[0].d);
            check("flit_tail", flit_tail_o, sb_q[0].t);
            check("grant_id", grant_id_o, sb_q[0].g);
            if (flit_ready_i) begin
                gnt_log.push_back(int'(grant_id_o));
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        #1;
        check("rst_valid", flit_valid_o, 0);
        check("rst_data", flit_data_o, 0);
        check("rst_tail", flit_tail_o, 0);
        check("rst_grant", grant_id_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", req_ready_o, 0);
        repeat (3) @(posedge clk);
        #3 arst_axi = 1'b1;

        // Four single-flit packets: grants 0,1,2,3 back to back.
        for (int i = 0; i < N; i++) add_pkt(i, 1);
        wait_drain(100);
        exp_g = '{0, 1, 2, 3};
        check_gnt("t1_order");

        // Locked 3-flit packet from req1 holds off req2.
        add_pkt(1, 3);
        add_pkt(2, 1);
        wait_drain(100);
        exp_g = '{1, 1, 1, 2};
        check_gnt("t2_lock");

        // rr_ptr is now 3: req3 before req0.
        add_pkt(0, 1);
        add_pkt(3, 1);
        wait_drain(100);
        exp_g = '{3, 0};
        check_gnt("t3_wrap");

        // Backpressure for 5 cycles mid-packet.
        add_pkt(0, 4);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = flit_valid_o;
        end
        check("t4_seen", seen, 1);
        rdy_pct = 0;
        repeat (5) @(posedge clk);
        #2 rdy_pct = 100;
        wait_drain(100);
        exp_g = '{0, 0, 0, 0};
        check_gnt("t4_bp");

        // Owner bubbles while req0 waits.
        add_pkt(1, 4);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = (src_q[1].size() <= 3);
        end
        check("t5_started", seen, 1);
        pause[1] = 1'b1;
        add_pkt(0, 1);
        repeat (4) @(negedge clk);
        check("t5_busy", busy_o, 1);
        check("t5_no_req0", req_ready_o[0], 0);
        pause[1] = 1'b0;
        wait_drain(100);
        exp_g = '{1, 1, 1, 1, 0};
        check_gnt("t5_bubble");

        // Reset mid-packet, then round robin restarts at 0.
        add_pkt(2, 4);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = (src_q[2].size() <= 2);
        end
        check("t6_busy_pre", busy_o, 1);
        @(posedge clk);
        #3 arst_axi = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        #1;
        check("t6_valid", flit_valid_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_ready", req_ready_o, 0);
        repeat (2) @(posedge clk);
        #3 arst_axi = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < N; i++) add_pkt(i, 1);
        wait_drain(100);
        exp_g = '{0, 1, 2, 3};
        check_gnt("t6_restart");

        // Random traffic with bubbles and backpressure.
        bubble_pct = 30;
        rdy_pct    = 70;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0 && src_total() < 16)
                add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
        end
        bubble_pct = 0;
        rdy_pct    = 100;
        wait_drain(3000);

`ifdef RAVENOC_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("pkt_cnt", pkt_cnt_o[i*CW +: CW], CW'(m_cnt[i]));
        @(posedge clk);
        #1 stats_clr_i = 1'b1;
        @(posedge clk);
        #1 stats_clr_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check("pkt_cnt_clr", pkt_cnt_o[i*CW +: CW], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
